alu_operand_issue: RTL and testbench

- Issue-side producer for the combinational execute ALU: captures decoded instructions, selects and forwards operands, and presents registered op1/op2/alu_ops to the ALU.
- Sits between decode/register-read and execute. Valid/ready handshake on both sides, a 2-entry skid buffer for full throughput, a flush, and a single late forwarding source applied to buffered entries.

---
 rtl/alu_operand_issue_if.sv | 41 ++++
 rtl/alu_operand_issue.sv | 79 +++++++
 tb/tb_alu_operand_issue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// alu_operand_issue_if: issue-stage bundle (decode side, late forward, flush, execute side)
// master = upstream/testbench driver, slave = alu_operand_issue
interface alu_operand_issue_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs1_addr;
  logic [RADDR_W-1:0] in_rs2_addr;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  logic [XLEN-1:0]    in_pc;
  logic [1:0]         in_op1_sel;
  logic               in_op2_sel;
  logic [4:0]         in_alu_ops;
  logic [RADDR_W-1:0] in_rd_addr;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [XLEN-1:0]    fwd_data;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    op1;
  logic [XLEN-1:0]    op2;
  logic [4:0]         alu_ops;
  logic [RADDR_W-1:0] out_rd_addr;
  modport master (
    output flush, in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_op1_sel, in_op2_sel, in_alu_ops, in_rd_addr,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, op1, op2, alu_ops, out_rd_addr
  );
  modport slave (
    input  flush, in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_op1_sel, in_op2_sel, in_alu_ops, in_rd_addr,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, op1, op2, alu_ops, out_rd_addr
  );
endinterface

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: 2-entry skid-buffered operand issue stage with late forwarding and flush
// clk/rst_n: clock, async active-low reset; bus: alu_operand_issue_if.slave
// stall_cnt: output-stall cycle counter, present only with ALU_ISSUE_STALL_CNT_EN
module alu_operand_issue #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_operand_issue_if.slave    bus
`ifdef ALU_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);
  typedef struct packed {
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [1:0]         op1_sel;
    logic               op2_sel;
    logic [4:0]         alu_ops;
    logic [RADDR_W-1:0] rd;
  } entry_t;
  function automatic entry_t fwd(entry_t e, logic v, logic [RADDR_W-1:0] rd, logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (v && rd != '0 && rd == e.rs1_addr) r.rs1_data = d;
    if (v && rd != '0 && rd == e.rs2_addr) r.rs2_data = d;
    return r;
  endfunction
  entry_t in_raw, in_e, out_f, skid_f, out_d, out_q, skid_d, skid_q;
  logic out_valid_d, out_valid_q, skid_valid_d, skid_valid_q, accept, drain, load;
  assign in_raw = '{rs1_addr: bus.in_rs1_addr, rs2_addr: bus.in_rs2_addr,
                    rs1_data: bus.in_rs1_data, rs2_data: bus.in_rs2_data,
                    imm: bus.in_imm, pc: bus.in_pc, op1_sel: bus.in_op1_sel,
                    op2_sel: bus.in_op2_sel, alu_ops: bus.in_alu_ops, rd: bus.in_rd_addr};
  // load: OUT is free to take a new entry this edge (empty or being drained)
  always_comb begin
    in_e         = fwd(in_raw, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    out_f        = fwd(out_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    skid_f       = fwd(skid_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    accept       = bus.in_valid && !skid_valid_q;
    drain        = out_valid_q && bus.out_ready;
    load         = !out_valid_q || drain;
    out_valid_d  = !bus.flush && (skid_valid_q || accept || !load);
    skid_valid_d = !bus.flush && !load && (skid_valid_q || accept);
    out_d        = !load ? out_f : skid_valid_q ? skid_f : accept ? in_e : out_f;
    skid_d       = (!load && accept) ? in_e : skid_f;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.op1         = out_q.op1_sel == 2'd0 ? out_q.rs1_data : out_q.op1_sel == 2'd1 ? out_q.pc : '0;
  assign bus.op2         = out_q.op2_sel ? out_q.imm : out_q.rs2_data;
  assign bus.alu_ops     = out_q.alu_ops;
  assign bus.out_rd_addr = out_q.rd;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else if (out_valid_q && !bus.out_ready && !bus.flush) stall_q <= stall_q + 32'd1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: randomized scoreboard bench for alu_operand_issue against a 2-deep queue model
module tb_alu_operand_issue;
  localparam int XLEN = 32, RW = 5;
  localparam logic [4:0] ADD = 5'd0;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_operand_issue_if #(.XLEN(XLEN), .RADDR_W(RW)) bus ();
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  alu_operand_issue #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ALU_ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  typedef struct {
    logic [RW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] d1, d2, imm, pc;
    logic [1:0] s1;
    logic s2;
    logic [4:0] op;
  } ent_t;
  typedef struct {
    logic [XLEN-1:0] op1, op2;
    logic [4:0] op;
    logic [RW-1:0] rd;
  } exp_t;
  ent_t mq[$];
  exp_t sb[$];
  int tests = 0, fails = 0;
  logic [31:0] stall_m = '0;
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic ent_t fw(ent_t e);
    ent_t r = e;
    if (bus.fwd_valid && bus.fwd_rd != 0 && bus.fwd_rd == e.rs1) r.d1 = bus.fwd_data;
    if (bus.fwd_valid && bus.fwd_rd != 0 && bus.fwd_rd == e.rs2) r.d2 = bus.fwd_data;
    return r;
  endfunction
  function automatic exp_t expect_of(ent_t e);
    exp_t x;
    x.op1 = e.s1 == 2'd0 ? e.d1 : e.s1 == 2'd1 ? e.pc : '0;
    x.op2 = e.s2 ? e.imm : e.d2;
    x.op  = e.op;
    x.rd  = e.rd;
    return x;
  endfunction
  function automatic ent_t from_bus();
    ent_t e;
    e.rs1 = bus.in_rs1_addr; e.rs2 = bus.in_rs2_addr; e.rd = bus.in_rd_addr;
    e.d1 = bus.in_rs1_data; e.d2 = bus.in_rs2_data; e.imm = bus.in_imm; e.pc = bus.in_pc;
    e.s1 = bus.in_op1_sel; e.s2 = bus.in_op2_sel; e.op = bus.in_alu_ops;
    return e;
  endfunction
  // One clock: predict this cycle's emitted entry, advance the queue model at the edge.
  task automatic tick();
    int n;
    bit acc;
    if (mq.size() > 0 && bus.out_ready && !bus.flush) sb.push_back(expect_of(mq[0]));
    @(posedge clk);
    if (rst_n) begin
      n = mq.size();
      acc = bus.in_valid && n < 2;
      if (n > 0 && !bus.out_ready && !bus.flush) stall_m++;
      if (bus.flush) mq.delete();
      else begin
        if (n > 0 && bus.out_ready) void'(mq.pop_front());
        foreach (mq[i]) mq[i] = fw(mq[i]);
        if (acc) mq.push_back(fw(from_bus()));
      end
    end
    #1;
  endtask
  task automatic set_in(input logic v, input logic [RW-1:0] a1, a2, input logic [XLEN-1:0] d1, d2, imm, pc,
                        input logic [1:0] s1, input logic s2, input logic [4:0] op, input logic [RW-1:0] rd);
    bus.in_valid = v; bus.in_rs1_addr = a1; bus.in_rs2_addr = a2; bus.in_rs1_data = d1;
    bus.in_rs2_data = d2; bus.in_imm = imm; bus.in_pc = pc; bus.in_op1_sel = s1;
    bus.in_op2_sel = s2; bus.in_alu_ops = op; bus.in_rd_addr = rd;
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_op1", bus.op1, 0);
    check("rst_op2", bus.op2, 0);
    check("rst_alu_ops", bus.alu_ops, 0);
    check("rst_rd", bus.out_rd_addr, 0);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    mq.delete();
    sb.delete();
    stall_m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    check("out_valid", bus.out_valid, mq.size() > 0);
    check("in_ready", bus.in_ready, mq.size() < 2);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
`endif
    if (bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got op1=%0h with none expected at %0t", bus.op1, $time);
      end else begin
        e = sb.pop_front();
        check("op1", bus.op1, e.op1);
        check("op2", bus.op2, e.op2);
        check("alu_ops", bus.alu_ops, e.op);
        check("rd", bus.out_rd_addr, e.rd);
      end
    end else if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL missing_output: got out_valid=%0b expected an entry at %0t", bus.out_valid, $time);
      sb.delete();
    end
  end
  initial begin
    bus.flush = 0; bus.fwd_valid = 0; bus.fwd_rd = 0; bus.fwd_data = 0; bus.out_ready = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_op1", bus.op1, 0);
    check("reset_op2", bus.op2, 0);
    rst_n = 1'b1;
    // basic ADD capture, one-cycle latency
    set_in(1, 1, 2, 5, 9, 7, 32'h100, 0, 1, ADD, 6);
    tick();
    bus.in_valid = 0;
    check("lat_out_valid", bus.out_valid, 1'b1);
    check("lat_op1", bus.op1, 5);
    check("lat_op2", bus.op2, 7);
    check("lat_alu_ops", bus.alu_ops, ADD);
    bus.out_ready = 1;
    tick();
    // fill OUT and SKID, then drain in order
    bus.out_ready = 0;
    set_in(1, 1, 2, 32'hA1, 32'hA2, 0, 32'h200, 0, 0, 5'd3, 7);
    tick();
    set_in(1, 1, 2, 32'hB1, 32'hB2, 0, 32'h204, 1, 1, 5'd4, 8);
    tick();
    check("skid_full_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (3) tick();
    // forwarding into a held entry, and x0 never forwarded
    bus.out_ready = 0;
    set_in(1, 1, 3, 0, 1, 0, 0, 0, 0, 5'd1, 9);
    tick();
    bus.in_valid = 0;
    bus.fwd_valid = 1; bus.fwd_rd = 3; bus.fwd_data = 32'h55;
    tick();
    check("fwd_held_op2", bus.op2, 32'h55);
    bus.fwd_valid = 0;
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    set_in(1, 1, 0, 0, 1, 0, 0, 0, 0, 5'd1, 9);
    tick();
    bus.in_valid = 0;
    bus.fwd_valid = 1; bus.fwd_rd = 0; bus.fwd_data = 32'h55;
    tick();
    check("fwd_x0_op2", bus.op2, 1);
    // forwarding at capture beats register-file data
    bus.fwd_rd = 4; bus.fwd_data = 32'hAA;
    bus.out_ready = 1;
    set_in(1, 4, 0, 32'h11, 0, 0, 0, 0, 0, ADD, 2);
    tick();
    bus.fwd_valid = 0; bus.in_valid = 0; bus.out_ready = 0;
    check("fwd_capture_op1", bus.op1, 32'hAA);
    // flush with both entries held and a new input offered
    set_in(1, 1, 2, 32'hC1, 0, 0, 0, 0, 0, 5'd2, 3);
    tick();
    check("pre_flush_in_ready", bus.in_ready, 1'b0);
    set_in(1, 1, 2, 32'hD1, 0, 0, 0, 0, 0, 5'd2, 4);
    bus.flush = 1;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1;
    repeat (3) tick();
    // async reset mid-operation
    bus.out_ready = 0;
    set_in(1, 1, 2, 32'hE1, 0, 0, 0, 0, 0, 5'd2, 5);
    repeat (3) tick();
    async_reset();
    // stall counting from a clean reset
    set_in(1, 1, 2, 32'hF1, 0, 0, 0, 0, 0, 5'd2, 5);
    tick();
    bus.in_valid = 0;
    repeat (10) tick();
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_cnt_10", stall_cnt, 10);
`endif
    async_reset();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.in_valid && !bus.in_ready))
        set_in($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
               $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 31));
      bus.fwd_valid = $urandom_range(0, 1);
      bus.fwd_rd = $urandom_range(0, 3);
      bus.fwd_data = $urandom;
      bus.out_ready = $urandom_range(0, 9) < 6;
      bus.flush = $urandom_range(0, 15) == 0;
      tick();
    end
    bus.flush = 0; bus.in_valid = 0; bus.fwd_valid = 0; bus.out_ready = 1;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
